// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side circular FIFO between the UART receiver and the APB slave.
// Captures a byte on each rx_done pulse and exposes the oldest byte on a show-ahead read port.
// Reports fill level, full/empty status and a sticky overflow flag.
// Optional feature macro: UART_RX_FIFO_AFULL_EN adds a registered almost_full output.
module uart_rx_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  ovf_clr,
    input  logic                  flush
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    output logic                  almost_full
`endif
);

    localparam int unsigned          CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

    // Reject unusable geometries at elaboration time
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LEVEL > DEPTH) begin : g_param_check
        $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and AFULL_LEVEL <= DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] rd_ptr_nxt;
    logic [CNT_WIDTH-1:0]  count_nxt;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic                  overflow_nxt;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;

    // Next-state decode: flush wins over push/pop; a pop frees room for a write when full
    always_comb begin
        pop          = rd_en && !empty && !flush;
        push         = wr_en && !flush && (!full || pop);
        ovf_set      = wr_en && !flush && full && !pop;
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt   = rd_ptr;
        count_nxt    = count;
        rd_data_nxt  = '0;
        overflow_nxt = overflow;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + ADDR_WIDTH'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + ADDR_WIDTH'(1);
            if (push && !pop)      count_nxt = count + CNT_WIDTH'(1);
            else if (pop && !push) count_nxt = count - CNT_WIDTH'(1);
        end

        // Head of the next cycle; bypass when the new head is the byte being written now
        if (count_nxt == '0)                  rd_data_nxt = '0;
        else if (push && wr_ptr == rd_ptr_nxt) rd_data_nxt = wr_data;
        else                                   rd_data_nxt = mem[rd_ptr_nxt];

        // Set beats clear when both happen in the same cycle
        if (ovf_set)      overflow_nxt = 1'b1;
        else if (ovf_clr) overflow_nxt = 1'b0;
    end

    // Control and status registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            empty    <= (count_nxt == '0);
            full     <= (count_nxt == DEPTH_CNT);
            overflow <= overflow_nxt;
            rd_data  <= rd_data_nxt;
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

`ifdef UART_RX_FIFO_AFULL_EN
    // Flow-control threshold flag, decoded from the next count so it tracks count exactly
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) almost_full <= 1'b0;
        else       almost_full <= (count_nxt >= CNT_WIDTH'(AFULL_LEVEL));
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed steps with a queue scoreboard.
// Checks almost_full as well when UART_RX_FIFO_AFULL_EN is defined.
module tb_uart_rx_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned AFULL = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;
    logic          flush;
`ifdef UART_RX_FIFO_AFULL_EN
    logic          almost_full;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_q[$];
    logic          m_ovf;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .AFULL_LEVEL(AFULL)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overflow(overflow),
        .ovf_clr (ovf_clr),
        .flush   (flush)
`ifdef UART_RX_FIFO_AFULL_EN
        ,
        .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every status output with the scoreboard model
    task automatic check_state(input string tag);
        logic [DW-1:0] head;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check({tag, ".count"},    32'(count),    32'(m_q.size()));
        check({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
        check({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".rd_data"},  32'(rd_data),  32'(head));
`ifdef UART_RX_FIFO_AFULL_EN
        check({tag, ".almost_full"}, 32'(almost_full), 32'(m_q.size() >= AFULL));
`endif
    endtask

    // One clock of stimulus; popped data is checked against the scoreboard before the edge
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                         input logic fl, input logic oc);
        logic pop;
        logic wacc;
        logic set;
        wr_en = we; wr_data = wd; rd_en = re; flush = fl; ovf_clr = oc;
        pop  = re && (m_q.size() != 0);
        wacc = we && ((m_q.size() < DEPTH) || pop);
        set  = we && !wacc && !fl;
        if (fl) begin
            m_q.delete();
        end else begin
            if (pop) check("pop_data", 32'(rd_data), 32'(m_q.pop_front()));
            if (wacc) m_q.push_back(wd);
        end
        if (set)     m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        check_state("cyc");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.count", 32'(count), 32'd0);
        check("rst.empty", 32'(empty), 32'd1);
        check("rst.full", 32'(full), 32'd0);
        check("rst.overflow", 32'(overflow), 32'd0);
        check("rst.rd_data", 32'(rd_data), 32'd0);
        rstn = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);

        // Three characters in, three out in order
        cycle(1, 8'h41, 0, 0, 0);
        cycle(1, 8'h42, 0, 0, 0);
        cycle(1, 8'h43, 0, 0, 0);
        check("abc.count", 32'(count), 32'd3);
        check("abc.empty", 32'(empty), 32'd0);
        check("abc.head", 32'(rd_data), 32'h41);
        repeat (3) cycle(0, 8'h00, 1, 0, 0);
        check("abc.empty_after", 32'(empty), 32'd1);
        check("abc.rd_data_after", 32'(rd_data), 32'h00);
        cycle(0, 8'h00, 1, 0, 0);

        // Fill, overflow with 0xFF, drain, clear the sticky flag
        for (int i = 0; i < 16; i++) cycle(1, 8'(i), 0, 0, 0);
        cycle(1, 8'hFF, 0, 0, 0);
        check("ovf.full", 32'(full), 32'd1);
        check("ovf.count", 32'(count), 32'd16);
        check("ovf.overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("ovf.drain", 32'(rd_data), 32'(i));
            cycle(0, 8'h00, 1, 0, 0);
        end
        cycle(0, 8'h00, 0, 0, 1);
        check("ovf.cleared", 32'(overflow), 32'd0);

        // Write and pop together while full
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h20 + i), 0, 0, 0);
        cycle(1, 8'hAA, 1, 0, 0);
        check("wrrd_full.count", 32'(count), 32'd16);
        check("wrrd_full.overflow", 32'(overflow), 32'd0);
        repeat (15) cycle(0, 8'h00, 1, 0, 0);
        check("wrrd_full.last", 32'(rd_data), 32'hAA);
        cycle(0, 8'h00, 1, 0, 0);

        // Write and pop together while empty
        cycle(1, 8'h5A, 1, 0, 0);
        check("wrrd_empty.count", 32'(count), 32'd1);
        check("wrrd_empty.head", 32'(rd_data), 32'h5A);
        cycle(0, 8'h00, 1, 0, 0);

        // Overflow together with ovf_clr: set wins
        for (int i = 0; i < 16; i++) cycle(1, 8'(8'h60 + i), 0, 0, 0);
        cycle(1, 8'hEE, 0, 0, 1);
        check("setwins.overflow", 32'(overflow), 32'd1);
        repeat (11) cycle(0, 8'h00, 1, 0, 0);
        check("flush.pre_count", 32'(count), 32'd5);

        // Flush with a concurrent write
        cycle(1, 8'h77, 0, 1, 0);
        check("flush.count", 32'(count), 32'd0);
        check("flush.empty", 32'(empty), 32'd1);
        check("flush.overflow", 32'(overflow), 32'd1);

        // Streaming across the pointer wrap
        cycle(1, 8'h80, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 8'(8'h81 + i), 1, 0, 0);
        check("wrap.head", 32'(rd_data), 32'h94);
        cycle(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 8'(8'hC0 + i), 0, 0, 0);
            cycle(0, 8'h00, 1, 0, 0);
        end
        cycle(0, 8'h00, 0, 0, 1);

`ifdef UART_RX_FIFO_AFULL_EN
        // Almost-full threshold
        for (int i = 0; i < 11; i++) cycle(1, 8'(8'hA0 + i), 0, 0, 0);
        check("afull.11", 32'(almost_full), 32'd0);
        cycle(1, 8'hAB, 0, 0, 0);
        check("afull.12", 32'(almost_full), 32'd1);
        cycle(0, 8'h00, 1, 0, 0);
        check("afull.pop", 32'(almost_full), 32'd0);
`endif

        // Asynchronous reset mid-stream with data and overflow present
        while (m_q.size() < DEPTH) cycle(1, 8'h3C, 0, 0, 0);
        cycle(1, 8'hC3, 0, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.empty", 32'(empty), 32'd1);
        check("async_rst.full", 32'(full), 32'd0);
        check("async_rst.overflow", 32'(overflow), 32'd0);
        check("async_rst.rd_data", 32'(rd_data), 32'd0);
`ifdef UART_RX_FIFO_AFULL_EN
        check("async_rst.almost_full", 32'(almost_full), 32'd0);
`endif
        m_q.delete();
        m_ovf = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cycle(0, 8'h00, 0, 0, 0);
        cycle(1, 8'h99, 0, 0, 0);
        check("post_rst.head", 32'(rd_data), 32'h99);
        cycle(0, 8'h00, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer placed directly downstream of the UART receiver. It captures each received byte on the receiver's single-cycle done pulse and stores it in a circular FIFO. The APB register slave then drains the FIFO through a show-ahead read port. It reports fill level, full/empty status and a sticky overflow error, so that back-to-back characters at 115200 baud are not lost while software is slow.

Parameters:
- DATA_WIDTH, 8, width of one received character.
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width.
- AFULL_LEVEL, 12, almost-full threshold in entries; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe; connected to the receiver's rx_done pulse.
- wr_data  input  DATA_WIDTH  received character; connected to the receiver's data_o.
- rd_en  input  1  pop request from the APB slave.
- rd_data  output  DATA_WIDTH  head entry (show-ahead).
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- count  output  ADDR_WIDTH+1  current number of entries, 0..DEPTH.
- overflow  output  1  sticky flag: a write was dropped.
- ovf_clr  input  1  clears overflow.
- flush  input  1  synchronous discard of all contents.

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rstn).
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, rd_data=0. Storage array is not reset.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- count is registered. empty = (count==0). full = (count==DEPTH). Both are decoded from the registered count, not from pointer compare.
- Write accepted when wr_en=1 and (full=0, or a pop occurs in the same cycle). Effect: mem[wr_ptr]<=wr_data; wr_ptr+1.
- Pop occurs when rd_en=1 and empty=0. Effect: rd_ptr+1.
- rd_en while empty is ignored: no pointer change, no error flag.
- count update: +1 on write only, -1 on pop only, unchanged on write+pop or on neither.
- Simultaneous write and pop:
  - When full: both happen; count stays DEPTH; no overflow.
  - When empty: only the write happens; count becomes 1.
- Write while full without a pop: data is dropped, pointers and count are unchanged, overflow<=1.
- overflow stays set until ovf_clr=1. If an overflow event and ovf_clr occur in the same cycle, set wins (overflow stays 1).
- flush=1: next edge sets wr_ptr=rd_ptr=0 and count=0. flush has priority over wr_en and rd_en in the same cycle; that write is discarded and does not set overflow. flush does not clear overflow.
- rd_data = mem[rd_ptr] when empty=0, and 0 when empty=1. Registered or async-read memory is acceptable, but rd_data must be valid in the same cycle that empty is 0.
- Latency: a byte written at edge N is visible on rd_data and empty=0 after edge N (cycle N+1), provided the FIFO was empty.
- Asserting rstn low mid-operation clears the contents immediately (asynchronously); overflow returns to 0.

Optional Feature:
- Macro UART_RX_FIFO_AFULL_EN.
- When defined: adds output almost_full (1 bit), registered, equal to (count >= AFULL_LEVEL), reset value 0. It is intended for flow-control or interrupt use.
- When undefined: the almost_full port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then three writes 0x41, 0x42, 0x43 on separate cycles -> count=3, empty=0, rd_data=0x41; three pops return 0x41, 0x42, 0x43 in order; then empty=1, rd_data=0x00.
- Write 16 bytes 0x00..0x0F, then a 17th write 0xFF -> full=1, count=16, overflow=1; popping 16 times returns 0x00..0x0F and 0xFF never appears; ovf_clr pulse -> overflow=0.
- FIFO full, wr_en and rd_en in the same cycle with wr_data=0xAA -> count stays 16, overflow stays 0; 0xAA is the last of the next 16 pops.
- FIFO empty, wr_en=1 with 0x5A and rd_en=1 in the same cycle -> count=1, rd_data=0x5A next cycle.
- 5 entries plus overflow set; flush=1 together with wr_en=1 -> count=0, empty=1, overflow still 1. Then 20 write/pop pairs crossing the pointer wrap -> data returned in order.
- With UART_RX_FIFO_AFULL_EN defined: 11 writes -> almost_full=0; 12th write -> almost_full=1; one pop -> almost_full=0. Assert rstn low mid-stream -> all outputs return to reset values within the same cycle.
